bank_cmd_seq: RTL and testbench

BANK_CMD_SEQ -- requirements
Module: bank_cmd_seq

---
 rtl/bank_cmd_seq.sv | 197 +++++++++++++++++++
 tb/tb_bank_cmd_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_seq.sv
// bank_cmd_seq: sequences one host read or write command at a time into a
// bank controller. It issues w_en/mac_en, waits out the command-to-sense-amp
// pipeline, captures the sensed column data (reads only) and holds a
// response until the host takes it.
//
// Parameters
//   LAT     cycles of bank controller pipeline between issue and sense (>= 1)
//   TO_CYC  CAPTURE watchdog limit in cycles (>= 1, used with the macro only)
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   req_valid/ready     host command handshake (ready only while idle)
//   req_write, req_mac  command type (1 = write) and mode (1 = MAC)
//   w_en, mac_en        registered controls to the bank controller
//   sa_en, sa_out       per-column sense enables and sensed data
//   rsp_valid/ready     response handshake
//   rsp_data            read data, 8'h00 for writes and timeouts
//   rsp_write           echo of the command type
//   rsp_err             watchdog timeout flag
//   op_cnt              completed responses, wraps at 16 bits
//
// Build option
//   BANK_SEQ_TIMEOUT_EN  adds a CAPTURE watchdog; without it CAPTURE waits
//                        forever and rsp_err is tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a command
// ISSUE    | one cycle with w_en/mac_en presented to the bank controller
// WAIT     | counting down the controller pipeline latency
// CAPTURE  | read only: waiting for all columns to report sa_en
// RESP     | response held until the host accepts it

module bank_cmd_seq #(
    parameter int LAT    = 2,
    parameter int TO_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mac,
    output logic        w_en,
    output logic        mac_en,
    input  logic [7:0]  sa_en,
    input  logic [7:0]  sa_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [15:0] op_cnt
);

    // Elaboration-time guard: both counters below assume at least one cycle.
    if (LAT < 1 || TO_CYC < 1) begin : g_param_check
        $error("bank_cmd_seq: LAT and TO_CYC must both be >= 1");
    end

    localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [WCW-1:0] wait_cnt;
    logic           accept;
    logic           sa_full;
    logic           rsp_fire;
    logic           wd_expired;

    assign accept   = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign sa_full  = (sa_en == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = rsp_write ? S_RESP : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (sa_full || wd_expired) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch, issue strobes, capture register and op counter.
    // rsp_write doubles as the latched command type for the WAIT decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            w_en      <= 1'b0;
            mac_en    <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_write <= 1'b0;
            op_cnt    <= 16'h0000;
        end else begin
            // w_en is only ever high during the single ISSUE cycle.
            w_en <= accept ? req_write : 1'b0;

            if (accept) begin
                mac_en    <= req_mac;
                rsp_write <= req_write;
                rsp_data  <= 8'h00;
            end

            if (state_q == S_ISSUE) begin
                wait_cnt <= WCW'(LAT - 1);
            end else if (state_q == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WCW'(1);
            end

            if (state_q == S_CAPTURE && sa_full) begin
                rsp_data <= sa_out;
            end

            if (rsp_fire) begin
                op_cnt <= op_cnt + 16'd1;
            end
        end
    end

`ifdef BANK_SEQ_TIMEOUT_EN
    localparam int TCW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [TCW-1:0] wd_cnt;
    logic           rsp_err_q;

    // Loaded on CAPTURE entry; a capture and an expiry on the same cycle
    // resolve in favour of the capture.
    assign wd_expired = (state_q == S_CAPTURE) && !sa_full && (wd_cnt == '0);
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT && state_d == S_CAPTURE) begin
                wd_cnt <= TCW'(TO_CYC - 1);
            end else if (state_q == S_CAPTURE && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - TCW'(1);
            end

            if (accept) begin
                rsp_err_q <= 1'b0;
            end else if (wd_expired) begin
                rsp_err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bank_cmd_seq.sv
module tb_bank_cmd_seq;

    localparam int LAT    = 2;
    localparam int TO_CYC = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_mac;
    logic        w_en;
    logic        mac_en;
    logic [7:0]  sa_en;
    logic [7:0]  sa_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_write;
    logic        rsp_err;
    logic [15:0] op_cnt;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_ops;

    bank_cmd_seq #(.LAT(LAT), .TO_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_mac   (req_mac),
        .w_en      (w_en),
        .mac_en    (mac_en),
        .sa_en     (sa_en),
        .sa_out    (sa_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // rst is applied at a negedge, sampled by the next posedge and released
    // at the following negedge; the model's op count restarts at zero.
    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_ops = 16'h0000;
    endtask

    // One complete command. The model: a write responds LAT+1 cycles after
    // the handshake edge; a read responds LAT+2+d cycles after it, where d
    // is how many cycles past the earliest sense point sa_en reaches 8'hFF.
    // The response is then held for bp cycles of backpressure.
    task automatic run_op(input logic wr, input logic mac, input int d,
                          input int bp, input logic [7:0] data);
        int         k;
        bit         seen;
        int         ready_at;
        int         exp_lat;
        logic [7:0] exp_data;
        ready_at = LAT + 2 + d;
        exp_lat  = wr ? (LAT + 1) : (LAT + 2 + d);
        exp_data = wr ? 8'h00 : data;
        chk1("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_mac   = mac;
        rsp_ready = 1'b0;
        sa_en     = 8'h00;
        @(negedge clk);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                chk1("w_en", w_en, (k == 0) ? wr : 1'b0);
                chk1("mac_en", mac_en, mac);
                chk1("req_ready_busy", req_ready, 1'b0);
                if (k + 1 >= ready_at) begin
                    sa_en  = 8'hFF;
                    sa_out = data;
                end else begin
                    sa_en  = 8'($urandom_range(0, 254));
                    sa_out = 8'($urandom);
                end
                // Host-side inputs wander while busy; none may matter.
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_mac   = 1'($urandom);
                rsp_ready = 1'($urandom);
                @(negedge clk);
                k++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk1("rsp_seen", seen, 1'b1);
        if (!seen) begin
            pulse_reset();
            @(negedge clk);
        end else begin
            chk16("latency", 16'(k), 16'(exp_lat));
            chk8("rsp_data", rsp_data, exp_data);
            chk1("rsp_write", rsp_write, wr);
            chk1("rsp_err", rsp_err, 1'b0);
            chk1("mac_en_resp", mac_en, mac);
            chk16("op_cnt_before", op_cnt, exp_ops);
            chk1("req_ready_resp", req_ready, 1'b0);
            for (int b = 0; b < bp; b++) begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                sa_en     = 8'hFF;
                sa_out    = 8'($urandom);
                @(negedge clk);
                chk1("bp_rsp_valid", rsp_valid, 1'b1);
                chk8("bp_rsp_data", rsp_data, exp_data);
                chk1("bp_rsp_write", rsp_write, wr);
                chk1("bp_req_ready", req_ready, 1'b0);
                chk16("bp_op_cnt", op_cnt, exp_ops);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            sa_en     = 8'h00;
            @(negedge clk);
            exp_ops   = exp_ops + 16'd1;
            rsp_ready = 1'b0;
            chk1("done_rsp_valid", rsp_valid, 1'b0);
            chk1("done_req_ready", req_ready, 1'b1);
            chk16("done_op_cnt", op_cnt, exp_ops);
        end
    endtask

    // Read with sa_en stuck short of all-ones.
    task automatic run_stuck();
        int first;
        first     = -1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_mac   = 1'($urandom);
        rsp_ready = 1'b0;
        sa_en     = 8'h0F;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid) begin
                first = k;
                break;
            end
            sa_out = 8'($urandom);
            @(negedge clk);
        end
`ifdef BANK_SEQ_TIMEOUT_EN
        chk16("timeout_latency", 16'(first), 16'(LAT + 1 + TO_CYC));
        chk1("timeout_rsp_err", rsp_err, 1'b1);
        chk8("timeout_rsp_data", rsp_data, 8'h00);
        if (first >= 0) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_ops   = exp_ops + 16'd1;
            chk16("timeout_op_cnt", op_cnt, exp_ops);
        end else begin
            pulse_reset();
        end
`else
        chk1("stuck_no_rsp", (first >= 0) ? 1'b1 : 1'b0, 1'b0);
        chk1("stuck_rsp_err", rsp_err, 1'b0);
        pulse_reset();
        chk1("stuck_recover_ready", req_ready, 1'b1);
`endif
        sa_en = 8'h00;
    endtask

    initial begin
        int n_rsp;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_mac   = 1'b0;
        rsp_ready = 1'b0;
        sa_en     = 8'h00;
        sa_out    = 8'h00;
        exp_ops   = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_w_en", w_en, 1'b0);
        chk1("rst_mac_en", mac_en, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk8("rst_rsp_data", rsp_data, 8'h00);
        chk1("rst_rsp_write", rsp_write, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk16("rst_op_cnt", op_cnt, 16'h0000);

        // Directed: CAM read, MAC write, read under 5 cycles of backpressure.
        run_op(1'b0, 1'b0, 0, 0, 8'hA5);
        run_op(1'b1, 1'b1, 0, 0, 8'h3C);
        run_op(1'b0, 1'b1, 2, 5, 8'h5A);

        run_stuck();
        run_op(1'b0, 1'b0, 1, 1, 8'hC3);

        // Reset while counting down in WAIT.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_mac   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        pulse_reset();
        chk1("wait_rst_req_ready", req_ready, 1'b1);
        chk1("wait_rst_rsp_valid", rsp_valid, 1'b0);
        chk16("wait_rst_op_cnt", op_cnt, 16'h0000);
        chk1("wait_rst_mac_en", mac_en, 1'b0);
        sa_en  = 8'hFF;
        sa_out = 8'h77;
        n_rsp  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk16("wait_rst_no_rsp", 16'(n_rsp), 16'd0);
        sa_en = 8'h00;

        // Reset in the ISSUE cycle while w_en is high.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_mac   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("issue_w_en", w_en, 1'b1);
        pulse_reset();
        chk1("issue_rst_w_en", w_en, 1'b0);
        chk1("issue_rst_req_ready", req_ready, 1'b1);
        n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk16("issue_rst_no_rsp", 16'(n_rsp), 16'd0);
        chk16("issue_rst_op_cnt", op_cnt, 16'h0000);

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), 8'($urandom));
        end

        // Counter wrap: preload the count as if 65534 ops had completed.
        force dut.op_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.op_cnt;
        exp_ops = 16'hFFFE;
        @(negedge clk);
        chk16("preload_op_cnt", op_cnt, exp_ops);
        run_op(1'b1, 1'b0, 0, 0, 8'h11);
        run_op(1'b0, 1'b1, 0, 2, 8'h22);
        chk16("wrap_op_cnt", op_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
